// File: rtl/cmd_frame_pkg.sv
// Shared constants, opcode check and FSM state types for the command frame handler.
package cmd_frame_pkg;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam logic [7:0] OP_A = 8'h41;
    localparam logic [7:0] OP_B = 8'h42;
    localparam logic [7:0] OP_C = 8'h43;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_WAIT = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

    function automatic logic is_valid_op(input logic [7:0] op);
        return (op == OP_A) || (op == OP_B) || (op == OP_C);
    endfunction

endpackage

// File: rtl/cmd_frame_if.sv
// UART-side byte handshake plus command/response outputs of the frame handler.
interface cmd_frame_if #(
    parameter int PAYLOAD_BYTES = 1
);
    logic                       rx_data_ready;
    logic [7:0]                 rx_data;
    logic                       tx_active;
    logic                       cmd_ready;
    logic [7:0]                 cmd_op;
    logic [8*PAYLOAD_BYTES-1:0] cmd_payload;
    logic                       tx_send;
    logic [7:0]                 tx_data;
    logic                       resp_overflow;

    modport master (
        output rx_data_ready, rx_data, tx_active,
        input  cmd_ready, cmd_op, cmd_payload, tx_send, tx_data, resp_overflow
    );

    modport slave (
        input  rx_data_ready, rx_data, tx_active,
        output cmd_ready, cmd_op, cmd_payload, tx_send, tx_data, resp_overflow
    );
endinterface

// File: rtl/cmd_resp_fifo.sv
// Small synchronous FIFO for ACK/NAK bytes; a pop in the same cycle frees room for a push when full.
module cmd_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/cmd_frame_handler.sv
// Frames UART bytes into opcode+payload commands and queues ACK/NAK responses to UART TX.
// Define CMD_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
//   state   | meaning
//   IDLE    | waiting for an opcode byte, no timeout running
//   PAYLOAD | collecting payload (and checksum) bytes under inter-byte timeout
//   TX_IDLE | waiting for a queued response and a quiet transmitter
//   TX_WAIT | byte handed over, waiting for tx_active to rise
//   TX_BUSY | waiting for tx_active to fall
module cmd_frame_handler
    import cmd_frame_pkg::*;
#(
    parameter int PAYLOAD_BYTES  = 1,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int RESP_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    cmd_frame_if.slave  bus
);
    localparam int PW = 8 * PAYLOAD_BYTES;
`ifdef CMD_CHECKSUM_EN
    localparam int TAIL_BYTES = PAYLOAD_BYTES + 1;
`else
    localparam int TAIL_BYTES = PAYLOAD_BYTES;
`endif
    localparam int             TOW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0]     LAST_IDX = 3'(TAIL_BYTES - 1);
    localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT_CYCLES - 1);

    rx_state_t      rx_state_q, rx_state_d;
    logic [2:0]     byte_cnt_q, byte_cnt_d;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]     op_q, op_d;
    logic [PW-1:0]  payload_q, payload_d, payload_shift;
    logic           cmd_ready_q, cmd_ready_d;
    logic [7:0]     cmd_op_q, cmd_op_d;
    logic [PW-1:0]  cmd_payload_q, cmd_payload_d;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]     csum_q, csum_d;
`endif

    tx_state_t      tx_state_q, tx_state_d;
    logic           tx_send_q, tx_send_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           overflow_q, overflow_d;

    logic           push, pop, fifo_full, fifo_empty;
    logic [7:0]     push_data, fifo_dout;
    logic           frame_ok;

    // New bytes enter at the LSB end so the first payload byte finishes in the MSBs.
    assign payload_shift = PW'({payload_q, bus.rx_data});

    always_comb begin
        rx_state_d    = rx_state_q;
        byte_cnt_d    = byte_cnt_q;
        to_cnt_d      = to_cnt_q;
        op_d          = op_q;
        payload_d     = payload_q;
        cmd_ready_d   = 1'b0;
        cmd_op_d      = cmd_op_q;
        cmd_payload_d = cmd_payload_q;
        push          = 1'b0;
        push_data     = NAK_BYTE;
        frame_ok      = 1'b0;
`ifdef CMD_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        case (rx_state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (bus.rx_data_ready) begin
                    op_d       = bus.rx_data;
                    byte_cnt_d = '0;
                    rx_state_d = PAYLOAD;
`ifdef CMD_CHECKSUM_EN
                    csum_d     = bus.rx_data;
`endif
                end
            end
            PAYLOAD: begin
                if (bus.rx_data_ready) begin
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 3'd1;
`ifdef CMD_CHECKSUM_EN
                    if (byte_cnt_q != LAST_IDX) begin
                        payload_d = payload_shift;
                        csum_d    = csum_q ^ bus.rx_data;
                    end
`else
                    payload_d = payload_shift;
`endif
                    if (byte_cnt_q == LAST_IDX) begin
                        rx_state_d = IDLE;
                        byte_cnt_d = '0;
                        push       = 1'b1;
`ifdef CMD_CHECKSUM_EN
                        frame_ok      = is_valid_op(op_q) && (csum_q == bus.rx_data);
                        cmd_payload_d = frame_ok ? payload_q : cmd_payload_q;
`else
                        frame_ok      = is_valid_op(op_q);
                        cmd_payload_d = frame_ok ? payload_shift : cmd_payload_q;
`endif
                        if (frame_ok) begin
                            cmd_ready_d = 1'b1;
                            cmd_op_d    = op_q;
                            push_data   = ACK_BYTE;
                        end
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    rx_state_d = IDLE;
                    to_cnt_d   = '0;
                    byte_cnt_d = '0;
                    push       = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TOW'(1);
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (!fifo_empty && !bus.tx_active) begin
                pop        = 1'b1;
                tx_state_d = TX_WAIT;
            end
            TX_WAIT: if (bus.tx_active)  tx_state_d = TX_BUSY;
            TX_BUSY: if (!bus.tx_active) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
        tx_send_d  = pop;
        tx_data_d  = pop ? fifo_dout : tx_data_q;
        overflow_d = overflow_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= IDLE;
            byte_cnt_q    <= '0;
            to_cnt_q      <= '0;
            op_q          <= '0;
            payload_q     <= '0;
            cmd_ready_q   <= 1'b0;
            cmd_op_q      <= '0;
            cmd_payload_q <= '0;
            tx_state_q    <= TX_IDLE;
            tx_send_q     <= 1'b0;
            tx_data_q     <= '0;
            overflow_q    <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            rx_state_q    <= rx_state_d;
            byte_cnt_q    <= byte_cnt_d;
            to_cnt_q      <= to_cnt_d;
            op_q          <= op_d;
            payload_q     <= payload_d;
            cmd_ready_q   <= cmd_ready_d;
            cmd_op_q      <= cmd_op_d;
            cmd_payload_q <= cmd_payload_d;
            tx_state_q    <= tx_state_d;
            tx_send_q     <= tx_send_d;
            tx_data_q     <= tx_data_d;
            overflow_q    <= overflow_d;
`ifdef CMD_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    cmd_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (8)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.cmd_op        = cmd_op_q;
    assign bus.cmd_payload   = cmd_payload_q;
    assign bus.tx_send       = tx_send_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.resp_overflow = overflow_q;

endmodule

// File: doc/cmd_frame_handler.md
Name: cmd_frame_handler

Overview:
Parametrised successor to the two-byte command handler.
- Assembles a UART byte stream into frames of one opcode byte plus PAYLOAD_BYTES payload bytes.
- Validates the opcode, enforces an inter-byte timeout, and publishes valid commands with a one-cycle strobe.
- Queues ACK/NAK response bytes into a small FIFO, which is drained to the UART TX under tx_active flow control.
- Sits between uart_rx and uart_tx, feeding the waveform generator control path.

Parameters:
PAYLOAD_BYTES, 1, payload bytes per frame (legal 1..4); 1 reproduces opcode+frequency format
TIMEOUT_CYCLES, 1000, clk cycles allowed between bytes of one frame before abort (>=2)
RESP_DEPTH, 4, response FIFO depth, power of 2 (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
rx_data_ready  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received byte
tx_active  in  1  UART TX busy
cmd_ready  out  1  one-cycle strobe: new valid command on cmd_op/cmd_payload
cmd_op  out  8  opcode of last valid command
cmd_payload  out  8*PAYLOAD_BYTES  payload, first received byte in MSBs
tx_send  out  1  one-cycle strobe to UART TX
tx_data  out  8  byte to transmit, valid while tx_send high
resp_overflow  out  1  sticky: a response was dropped because FIFO was full

Behaviour:
- Reset (rst high at a clk edge): all outputs 0, FSM to IDLE, byte and timeout counters 0, FIFO empty, TX FSM to TX_IDLE. Applies mid-frame and mid-transmit; partial frame discarded, no response queued.
- Valid opcodes: 0x41 'A', 0x42 'B', 0x43 'C'. Anything else is invalid.
- RX FSM states IDLE, PAYLOAD.
  - IDLE: on rx_data_ready, latch byte as opcode, clear byte counter, go to PAYLOAD.
  - PAYLOAD: on each rx_data_ready, shift the byte into the payload register and increment the counter. On the PAYLOAD_BYTES-th byte (the frame's last byte), evaluate the frame and return to IDLE the same edge. A byte arriving on the next cycle starts a new frame.
  - Invalid opcodes still consume a full frame; bytes are not resynchronised.
- Frame result, registered one cycle after the last-byte edge:
  - Valid: cmd_ready=1 for exactly one cycle, cmd_op/cmd_payload updated that cycle, push ACK 0x06.
  - Invalid: no cmd_ready, cmd_op/cmd_payload unchanged, push NAK 0x15.
- cmd_op/cmd_payload hold their value until the next valid frame.
- Timeout:
  - In PAYLOAD, a counter clears on every accepted byte and increments otherwise.
  - On reaching TIMEOUT_CYCLES: abort the frame, push NAK, go to IDLE.
  - A byte strobe in the same cycle as the terminal count wins: the byte is accepted and the counter is cleared.
  - No timeout in IDLE.
- Response FIFO:
  - Push on full: byte dropped, resp_overflow set (cleared only by rst).
  - Simultaneous push and pop when full: both succeed.
- TX FSM states TX_IDLE, TX_WAIT, TX_BUSY.
  - TX_IDLE: if FIFO non-empty and tx_active=0, pop and pulse tx_send for one cycle with tx_data = head byte, then go to TX_WAIT.
  - TX_WAIT: wait for tx_active=1, then go to TX_BUSY.
  - TX_BUSY: wait for tx_active=0, then go to TX_IDLE.
  - tx_data holds the last sent byte between sends.
- Latency: last byte sampled at edge N -> cmd_ready high in cycle N+1 -> earliest tx_send in cycle N+2.

Optional Feature:
CMD_CHECKSUM_EN
- Defined: each frame carries one extra trailing byte equal to the XOR of the opcode and all payload bytes. The frame ends on that byte. Mismatch -> NAK, no cmd_ready, even for a valid opcode. The timeout covers the checksum byte too.
- Undefined: no checksum byte; frame length is 1+PAYLOAD_BYTES; no checksum logic is synthesised.

Decomposition:
- Package cmd_frame_pkg: ACK_BYTE 0x06, NAK_BYTE 0x15, opcode constants OP_A/OP_B/OP_C, an is_valid_op function, rx_state_t (IDLE, PAYLOAD) and tx_state_t (TX_IDLE, TX_WAIT, TX_BUSY) enums.
- One sub-module, cmd_resp_fifo: synchronous FIFO, parameters DEPTH and WIDTH=8, ports push/pop/full/empty/din/dout.

Test Plan:
- PAYLOAD_BYTES=1: bytes 0x41, 0x55 -> cmd_ready one cycle after 0x55, cmd_op=0x41, cmd_payload=0x55, then tx_send with tx_data=0x06.
- Bytes 0x44, 0xAA -> no cmd_ready, cmd_op/cmd_payload keep 0x41/0x55, tx_data=0x15.
- PAYLOAD_BYTES=2: bytes 0x42, 0x12, 0x34 -> cmd_payload=0x1234, ACK. Then 0x43, 0x01, followed by TIMEOUT_CYCLES idle cycles -> NAK; a following 0x41, 0x00, 0x07 parses correctly.
- Hold tx_active=1, send 5 valid frames with RESP_DEPTH=4 -> resp_overflow=1; after tx_active is released, exactly 4 ACKs are sent, one per tx_active low period.
- Assert rst after the opcode byte of a frame -> all outputs 0, the next full frame 0x41, 0x7F decodes with no stale bytes.
- CMD_CHECKSUM_EN defined: 0x41, 0x55, 0x14 -> ACK and cmd_ready; 0x41, 0x55, 0x00 -> NAK, no cmd_ready.
